// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and defaults for the APB master arbiter.
//   state_e          - arbiter FSM states (IDLE / SETUP / ACCESS)
//   DEF_AW/DEF_DW    - default APB address / data widths
//   DEF_TIMEOUT      - default number of ACCESS cycles without pready before abort
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search.
//   req  [NREQ] - pending request bits
//   last [GW]   - index granted most recently; search starts at last+1
//   any         - at least one request pending
//   idx  [GW]   - first pending index at or after last+1, wrapping around
module rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic            any,
  output logic [GW-1:0]   idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Walk from the farthest candidate to the nearest so the nearest one
    // after 'last' is the final (winning) assignment. k = NREQ is 'last' itself.
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) idx = GW'((int'(last) + k) % NREQ);
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin APB master shared by NREQ requesters.
//   pclk, presetn          - clock, synchronous active-low reset
//   req_valid/write/addr/wdata - per-requester request (flat packed addr/wdata)
//   req_ready [NREQ]       - one-cycle accept pulse (in SETUP)
//   rsp_valid [NREQ]       - one-cycle completion pulse
//   rsp_rdata, rsp_err     - read data / timeout flag, valid with rsp_valid
//   grant_id, busy         - current/last grant, transfer in progress
//   psel/penable/pwrite/paddr/pwdata - APB master outputs
//   prdata, pready         - APB slave response
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [AW-1:0]        paddr,
  output logic [DW-1:0]        pwdata,
  input  logic [DW-1:0]        prdata,
  input  logic                 pready
);

  localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(NREQ - 1);

  state_e          state, state_d;
  logic [GW-1:0]   last_grant, last_grant_d;
  logic [CW-1:0]   tcnt, tcnt_d;

  logic [GW-1:0]   grant_d;
  logic            psel_d, penable_d, pwrite_d, busy_d, err_d;
  logic [AW-1:0]   paddr_d;
  logic [DW-1:0]   pwdata_d, rdata_d;
  logic [NREQ-1:0] ready_d, rspv_d;

  logic            pick_any;
  logic [GW-1:0]   pick_idx;

  rr_picker #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    tcnt_d       = tcnt;
    grant_d      = grant_id;
    psel_d       = psel;
    penable_d    = penable;
    pwrite_d     = pwrite;
    paddr_d      = paddr;
    pwdata_d     = pwdata;
    busy_d       = busy;
    rdata_d      = rsp_rdata;
    err_d        = rsp_err;
    ready_d      = '0;
    rspv_d       = '0;

    unique case (state)
      IDLE: begin
        if (pick_any) begin
          grant_d           = pick_idx;
          pwrite_d          = req_write[pick_idx];
          paddr_d           = req_addr[int'(pick_idx)*AW +: AW];
          pwdata_d          = req_wdata[int'(pick_idx)*DW +: DW];
          ready_d[pick_idx] = 1'b1;
          psel_d            = 1'b1;
          penable_d         = 1'b0;
          busy_d            = 1'b1;
          tcnt_d            = '0;
          state_d           = SETUP;
        end
      end
      SETUP: begin
        last_grant_d = grant_id;
        penable_d    = 1'b1;
        state_d      = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over the timeout limit in the same cycle.
        if (pready || tcnt == TLAST) begin
          rdata_d          = (pready && !pwrite) ? prdata : '0;
          err_d            = !pready;
          rspv_d[grant_id] = 1'b1;
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          busy_d           = 1'b0;
          tcnt_d           = '0;
          state_d          = IDLE;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state      <= IDLE;
      last_grant <= GLAST;   // requester 0 wins the first arbitration
      tcnt       <= '0;
      grant_id   <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      busy       <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      tcnt       <= tcnt_d;
      grant_id   <= grant_d;
      psel       <= psel_d;
      penable    <= penable_d;
      pwrite     <= pwrite_d;
      paddr      <= paddr_d;
      pwdata     <= pwdata_d;
      busy       <= busy_d;
      rsp_rdata  <= rdata_d;
      rsp_err    <= err_d;
      req_ready  <= ready_d;
      rsp_valid  <= rspv_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed literal checks followed by random
// traffic, with a transaction-level model compared on every cycle.
module tb_apb_master_arbiter;
  localparam int NREQ    = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int GW      = 1;

  logic                 pclk, presetn;
  logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata, pwdata, prdata;
  logic                 rsp_err, busy, psel, penable, pwrite, pready;
  logic [GW-1:0]        grant_id;
  logic [AW-1:0]        paddr;

  apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A transfer is "in flight" from grant until completion; m_age 1 is the
  // setup cycle, m_age 2 covers all access cycles.
  bit              chk_en = 0;
  bit              m_busy;
  int              m_last, m_age, m_waits;
  logic [NREQ-1:0] e_ready, e_rspv;
  logic [DW-1:0]   e_rdata, e_pwdata;
  logic [AW-1:0]   e_paddr;
  logic            e_err, e_pwrite, e_psel, e_pen, e_busy, e_rst;
  int              e_grant;

  task automatic model_step();
    int w;
    e_ready = '0;
    e_rspv  = '0;
    e_rst   = 1'b0;
    if (!presetn) begin
      m_busy = 0; m_last = NREQ - 1; e_grant = 0;
      e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_err = 0; e_rst = 1'b1;
    end else if (!m_busy) begin
      if (req_valid != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        m_busy = 1; m_age = 1; m_waits = 0;
        e_grant  = w;
        e_pwrite = req_write[w];
        e_paddr  = req_addr[w*AW +: AW];
        e_pwdata = req_wdata[w*DW +: DW];
        e_ready[w] = 1'b1;
      end
    end else if (m_age == 1) begin
      m_last = e_grant;
      m_age  = 2;
    end else if (pready) begin
      e_rspv[e_grant] = 1'b1; e_rdata = e_pwrite ? '0 : prdata; e_err = 1'b0; m_busy = 0;
    end else begin
      m_waits = m_waits + 1;
      if (m_waits == TIMEOUT) begin
        e_rspv[e_grant] = 1'b1; e_rdata = '0; e_err = 1'b1; m_busy = 0;
      end
    end
    e_psel = m_busy;
    e_pen  = m_busy && (m_age == 2);
    e_busy = m_busy;
    chk_en = 1;
  endtask

  initial forever begin
    @(posedge pclk);
    model_step();
  end

  // One compare process: every cycle once the model has seen an edge.
  initial forever begin
    @(negedge pclk);
    if (chk_en) begin
      chk("m_psel", psel, e_psel);
      chk("m_penable", penable, e_pen);
      chk("m_busy", busy, e_busy);
      chk("m_pwrite", pwrite, e_pwrite);
      chk("m_paddr", paddr, e_paddr);
      chk("m_pwdata", pwdata, e_pwdata);
      chk("m_grant", grant_id, e_grant);
      chk("m_req_ready", req_ready, e_ready);
      chk("m_rsp_valid", rsp_valid, e_rspv);
      if (e_rspv != '0 || e_rst) begin
        chk("m_rsp_rdata", rsp_rdata, e_rdata);
        chk("m_rsp_err", rsp_err, e_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge pclk);
    #1;
  endtask

  // Post one request, count cycles until completion. rdy_at is the access
  // cycle index (0-based) where pready rises; -1 never.
  task automatic xfer(input int id, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int rdy_at, input logic [31:0] rd,
                      output int pen, output int lat, output int rdy_cnt, output bit done,
                      output logic err, output logic [31:0] rdata,
                      output logic [NREQ-1:0] rv, output logic ps);
    req_valid[id] = 1'b1; req_write[id] = wr;
    req_addr[id*AW +: AW] = a; req_wdata[id*DW +: DW] = d;
    prdata = rd; pready = 1'b0;
    tick();
    lat = 1; pen = 0; done = 0; rdy_cnt = 0;
    err = 1'bx; rdata = 'x; rv = 'x; ps = 1'bx;
    if (req_ready[id]) rdy_cnt++;
    req_valid[id] = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      tick();
      lat++;
      if (req_ready[id]) rdy_cnt++;
      if (rsp_valid != '0) begin
        done = 1; err = rsp_err; rdata = rsp_rdata; rv = rsp_valid; ps = psel;
      end else if (penable) begin
        pen++;
        pready = (pen - 1 == rdy_at);
      end
    end
    pready = 1'b0;
    chk("xfer_completed", done, 1'b1);
  endtask

  int pen, lat, rdy_cnt;
  bit done;
  logic err_o, ps_o;
  logic [31:0] rd_o;
  logic [NREQ-1:0] rv_o;

  initial begin
    presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0;
    repeat (3) tick();
    chk("rst_psel", psel, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_busy", busy, 1'b0);
    presetn = 1'b1;
    tick();

    // single write from requester 0
    req_valid = 2'b01; req_write = 2'b01; req_addr[0 +: AW] = 32'h8;
    req_wdata[0 +: DW] = 32'hA5A5_0001; pready = 1'b1;
    tick();
    chk("t1_setup_psel", psel, 1'b1);
    chk("t1_setup_penable", penable, 1'b0);
    chk("t1_req_ready", req_ready, 2'b01);
    chk("t1_paddr", paddr, 32'h8);
    chk("t1_pwdata", pwdata, 32'hA5A5_0001);
    chk("t1_pwrite", pwrite, 1'b1);
    req_valid = '0;
    tick();
    chk("t1_access_penable", penable, 1'b1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_psel_low", psel, 1'b0);

    // single read from requester 1
    xfer(1, 1'b0, 32'h4, 32'h0, 0, 32'h1, pen, lat, rdy_cnt, done, err_o, rd_o, rv_o, ps_o);
    chk("t2_rsp_valid", rv_o, 2'b10);
    chk("t2_rdata", rd_o, 32'h1);
    chk("t2_ready_once", rdy_cnt, 1);
    chk("t2_latency", lat, 3);

    // contention: both hold valid, grants alternate every 3 cycles
    req_write = '0; pready = 1'b1; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_grant", grant_id, k % 2);
      chk("t3_ready", req_ready, 2'b01 << (k % 2));
      tick();
      tick();
      chk("t3_rsp", rsp_valid, 2'b01 << (k % 2));
      if (k == 3) req_valid = '0;
    end
    pready = 1'b0;

    // three wait states
    xfer(0, 1'b0, 32'h10, 32'h0, 3, 32'hCAFE_0003, pen, lat, rdy_cnt, done, err_o, rd_o, rv_o, ps_o);
    chk("t4_penable_cycles", pen, 4);
    chk("t4_latency", lat, 6);
    chk("t4_rdata", rd_o, 32'hCAFE_0003);

    // timeout abort
    xfer(1, 1'b0, 32'h14, 32'h0, -1, 32'hDEAD_BEEF, pen, lat, rdy_cnt, done, err_o, rd_o, rv_o, ps_o);
    chk("t5_penable_cycles", pen, 16);
    chk("t5_latency", lat, 18);
    chk("t5_err", err_o, 1'b1);
    chk("t5_rdata", rd_o, 32'h0);
    chk("t5_psel_low", ps_o, 1'b0);
    chk("t5_rsp_valid", rv_o, 2'b10);

    // pready on the last allowed access cycle wins over the timeout
    xfer(0, 1'b0, 32'h18, 32'h0, 15, 32'h1234_5678, pen, lat, rdy_cnt, done, err_o, rd_o, rv_o, ps_o);
    chk("t5b_penable_cycles", pen, 16);
    chk("t5b_err", err_o, 1'b0);
    chk("t5b_rdata", rd_o, 32'h1234_5678);

    // reset during ACCESS of a transfer from requester 0
    req_valid = 2'b01; req_write = 2'b01; pready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    chk("t6_in_access", penable, 1'b1);
    presetn = 1'b0;
    tick();
    chk("t6_psel", psel, 1'b0);
    chk("t6_penable", penable, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rsp_valid", rsp_valid, 2'b00);
    chk("t6_paddr", paddr, 32'h0);
    presetn = 1'b1;
    req_valid = 2'b11;
    tick();
    chk("t6_regrant", grant_id, 1'b0);
    chk("t6_ready", req_ready, 2'b01);
    req_valid = '0; pready = 1'b1;
    tick();
    tick();
    chk("t6_rsp", rsp_valid, 2'b01);
    pready = 1'b0;

    // random traffic, alternating mostly-ready and mostly-stalled slave
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && e_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_write[i] = 1'($urandom);
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
      pready  = ((c / 500) % 2 == 1) ? ($urandom % 20 == 0) : ($urandom % 4 != 0);
      prdata  = $urandom;
      presetn = ($urandom % 250 != 0);
    end
    presetn = 1'b1; req_valid = '0; pready = 1'b1;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin APB master that shares one APB bus between `NREQ` internal requesters (CPU bridge, DMA, debug) and drives the GPIO APB slave interface. Each requester posts a single read or write over a valid/ready request port. The arbiter sequences the APB IDLE→SETUP→ACCESS protocol, waits on `pready`, and returns read data or a timeout error to the granted requester. It sits between the requesters and the `psel/penable/pwrite/paddr/pwdata` inputs of the GPIO slave.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters (≥2).
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 16: number of ACCESS cycles without `pready` before abort (≥1).
- `GW` (derived) = max(1, clog2(`NREQ`)).

Ports (one clock; reset is synchronous and active-low):
- `pclk` in 1: clock.
- `presetn` in 1: synchronous active-low reset.
- `req_valid` in `NREQ`: request pending, one bit per requester.
- `req_write` in `NREQ`: 1 = write, 0 = read.
- `req_addr` in `NREQ*AW`: flat; requester i uses bits [i*AW +: AW].
- `req_wdata` in `NREQ*DW`: flat, same packing.
- `req_ready` out `NREQ`: one-cycle accept pulse to the granted requester.
- `rsp_valid` out `NREQ`: one-cycle completion pulse.
- `rsp_rdata` out `DW`: read data; valid with `rsp_valid`.
- `rsp_err` out 1: timeout flag; valid with `rsp_valid`.
- `grant_id` out `GW`: index of the current or last granted requester.
- `busy` out 1: high in SETUP and ACCESS.
- `psel`, `penable`, `pwrite` out 1: APB master controls.
- `paddr` out `AW`, `pwdata` out `DW`: APB master address and write data.
- `prdata` in `DW`, `pready` in 1: APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any `req_valid`, pick the winner by round-robin, searching from `last_grant+1` mod `NREQ` upward with wrap-around.
  - Latch the winner's write, addr and wdata into `pwrite/paddr/pwdata` and set `grant_id`.
  - Go to SETUP.
  - If no request, stay in IDLE.
- SETUP:
  - `psel`=1, `penable`=0, `req_ready[grant_id]`=1 for this cycle only.
  - `last_grant` ← `grant_id`.
  - Always go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1. The timeout counter increments each cycle `pready`=0.
  - If `pready`=1: `rsp_rdata` ← `prdata` on reads, or 0 on writes. Set `rsp_err`=0, pulse `rsp_valid[grant_id]`, go to IDLE.
  - If the counter reaches `TIMEOUT`-1 with `pready`=0: abort. Set `rsp_rdata`=0, `rsp_err`=1, pulse `rsp_valid[grant_id]`, go to IDLE.
- Requester rule: hold `req_valid` and the request fields stable until `req_ready` is seen. The arbiter ignores `req_valid` outside IDLE, so a requester that drops or re-asserts valid mid-transfer is not sampled.
- Only one outstanding transfer at a time. No back-to-back SETUP: every transfer passes through IDLE.
- `paddr/pwdata/pwrite` hold their values in IDLE until the next grant.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `last_grant`=`NREQ`-1 (so requester 0 wins first). All other outputs and internal registers reset to 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `grant_id`, `busy`, and the timeout counter.
- Sequence with `pready` tied 1:
  - Cycle 0: `req_valid` seen in IDLE.
  - Cycle 1: SETUP, `req_ready` pulse.
  - Cycle 2: ACCESS.
  - Cycle 3: `rsp_valid` pulse, back in IDLE.
  - Cycle 3: the next request is sampled; next SETUP at cycle 4. Throughput is 1 transfer per 3 cycles.
- Each wait state (`pready`=0) adds one cycle. With a timeout, `rsp_valid` arrives `TIMEOUT` cycles after ACCESS entry.
- `rsp_valid` and `req_ready` are never high for more than one cycle, and never for more than one requester.
- Reset asserted mid-transfer: on the next edge all outputs return to reset values. No `rsp_valid` is issued for the aborted transfer, and `psel` drops immediately.
- Simultaneous `pready` and timeout-limit in the same cycle: `pready` wins, `rsp_err`=0.

## Structure
- Package `apb_arb_pkg`: state enum (IDLE/SETUP/ACCESS) and the default `AW/DW/TIMEOUT` constants.
- Sub-module `rr_picker`:
  - Combinational round-robin search over `req_valid` from `last_grant+1` with wrap-around.
  - Outputs `any` and `idx[GW]`.
- The top level holds the FSM, request latch, timeout counter and response registers.

## Test plan
- Single write: requester 0 writes addr 0x08, data 0xA5A5_0001, `pready`=1 → SETUP at cycle 1 and ACCESS at cycle 2 with `paddr`=0x08, `pwdata`=0xA5A5_0001, `pwrite`=1; `rsp_valid[0]` at cycle 3, `rsp_err`=0.
- Single read: requester 1 reads 0x04, `prdata`=0x0000_0001 → `rsp_rdata`=0x1, `rsp_valid[1]` pulses, `req_ready[1]` seen exactly once.
- Contention: both requesters hold valid continuously for 4 transfers → grants go 0,1,0,1, each transfer 3 cycles apart.
- Wait states: `pready` low for 3 ACCESS cycles → `penable` is high for 4 cycles and `rsp_valid` arrives 3 cycles later than with no wait states.
- Timeout: `TIMEOUT`=16, `pready` held 0 → abort after 16 ACCESS cycles with `rsp_err`=1, `rsp_rdata`=0, `psel` low the next cycle. Also check `pready`=1 on cycle 16 → normal completion.
- Reset in ACCESS: `presetn`=0 for 1 cycle → all outputs 0 on the next edge, no `rsp_valid`, and the next grant goes to requester 0.
